fpdiv_iterative: RTL and testbench

Iterative fixed-point divider computing c = a / b on n-bit numbers with d fractional bits, the inverse counterpart of the team's iterative fixed-point multiplier. It uses the same recv/send val/rdy handshake, so it drops into the same accelerator pipelines. It is a restoring divider that produces one quotient bit per cycle. Divide-by-zero and overflow saturate and are flagged.

---
 rtl/fpdiv_pkg.sv | 15 +
 rtl/fpdiv_datapath.sv | 107 ++++++++++
 rtl/fpdiv_iterative.sv | 85 ++++++++
 tb/tb_fpdiv_iterative.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and defaults for the iterative fixed-point divider.
// State encoding is shared with the iterative multiplier control.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_DEF    = 32;
  localparam int unsigned D_DEF    = 16;
  localparam bit          SIGN_DEF = 1'b1;

endpackage

// File: rtl/fpdiv_datapath.sv
// Restoring-divider datapath: magnitudes, remainder, quotient, trial subtract.
// Ports: load_i latches operands, step_i retires one quotient bit;
// c_o/dbz_o/ovf_o are the signed, saturated result decoded from registers.
module fpdiv_datapath
  import fpdiv_pkg::*;
#(
  parameter int unsigned n    = N_DEF,
  parameter int unsigned d    = D_DEF,
  parameter bit          sign = SIGN_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] c_o,
  output logic         dbz_o,
  output logic         ovf_o
);

  localparam int unsigned W = n + d;

  localparam logic [W:0] LIM_U = (W+1)'((65'd1 << n) - 65'd1);
  localparam logic [W:0] LIM_P = (W+1)'((65'd1 << (n-1)) - 65'd1);
  localparam logic [W:0] LIM_N = (W+1)'(65'd1 << (n-1));

  localparam logic [n-1:0] SAT_MAX = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] SAT_MIN = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] SAT_ONE = {n{1'b1}};

  logic         sa_q, sb_q, dbz_q;
  logic [n-1:0] bm_q;
  logic [W-1:0] dv_q;
  logic [W-1:0] quo_q;
  logic [n:0]   rem_q;

  logic         sa_in, sb_in;
  logic [n-1:0] am_in, bm_in;
  logic [n:0]   rem_sh, bx, diff;
  logic         ge;

  always_comb begin
    sa_in = sign & a_i[n-1];
    sb_in = sign & b_i[n-1];
    am_in = sa_in ? (~a_i + 1'b1) : a_i;
    bm_in = sb_in ? (~b_i + 1'b1) : b_i;
  end

  // rem_q[n] set means the shifted remainder already exceeds any n-bit |b|
  always_comb begin
    rem_sh = {rem_q[n-1:0], dv_q[W-1]};
    bx     = {1'b0, bm_q};
    ge     = rem_q[n] | (rem_sh >= bx);
    diff   = rem_sh - bx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dbz_q <= 1'b0;
      bm_q  <= '0;
      dv_q  <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (load_i) begin
      sa_q  <= sa_in;
      sb_q  <= sb_in;
      dbz_q <= (b_i == '0);
      bm_q  <= bm_in;
      dv_q  <= W'(am_in) << d;
      quo_q <= '0;
      rem_q <= '0;
    end else if (step_i) begin
      dv_q  <= dv_q << 1;
      rem_q <= ge ? diff : rem_sh;
      quo_q <= {quo_q[W-2:0], ge};
    end
  end

  logic       neg;
  logic [W:0] qx, lim;

  always_comb begin
    neg = sa_q ^ sb_q;
    qx  = {1'b0, quo_q};
    lim = !sign ? LIM_U : (neg ? LIM_N : LIM_P);
  end

  // divide-by-zero takes precedence; its all-ones quotient would also overflow
  always_comb begin
    c_o   = '0;
    dbz_o = 1'b0;
    ovf_o = 1'b0;
    if (dbz_q) begin
      dbz_o = 1'b1;
      c_o   = !sign ? SAT_ONE : (sa_q ? SAT_MIN : SAT_MAX);
    end else if (qx > lim) begin
      ovf_o = 1'b1;
      c_o   = !sign ? SAT_ONE : (neg ? SAT_MIN : SAT_MAX);
    end else begin
      c_o = neg ? (~quo_q[n-1:0] + 1'b1) : quo_q[n-1:0];
    end
  end

endmodule

// File: rtl/fpdiv_iterative.sv
// Iterative restoring fixed-point divider, c = a / b, one bit per cycle.
// Ports: recv_val/recv_rdy/a/b operand side, send_val/send_rdy/c/dbz/ovf result side.
module fpdiv_iterative
  import fpdiv_pkg::*;
#(
  parameter int unsigned n    = N_DEF,
  parameter int unsigned d    = D_DEF,
  parameter bit          sign = SIGN_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c,
  output logic         dbz,
  output logic         ovf
);

  localparam int unsigned   CW   = $clog2(n + d);
  localparam logic [CW-1:0] LAST = CW'(n + d - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fpdiv_datapath #(
    .n    (n),
    .d    (d),
    .sign (sign)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c),
    .dbz_o  (dbz),
    .ovf_o  (ovf)
  );

endmodule

// File: tb/tb_fpdiv_iterative.sv
// Self-checking bench for fpdiv_iterative, signed and unsigned instances.
// Reference quotients come from 64-bit integer division in the bench.
module tb_fpdiv_iterative;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;
  localparam int     LAT  = 49;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_rv, s_rdy, s_sv, s_sr, s_dz, s_ov;
  logic [31:0] s_a, s_b, s_c;
  logic        u_rv, u_rdy, u_sv, u_sr, u_dz, u_ov;
  logic [31:0] u_a, u_b, u_c;

  int n_chk = 0;
  int n_fail = 0;

  fpdiv_iterative #(.n(32), .d(16), .sign(1'b1)) dut (
    .clk(clk), .reset(reset),
    .recv_val(s_rv), .recv_rdy(s_rdy), .a(s_a), .b(s_b),
    .send_val(s_sv), .send_rdy(s_sr), .c(s_c), .dbz(s_dz), .ovf(s_ov)
  );

  fpdiv_iterative #(.n(32), .d(16), .sign(1'b0)) dut_u (
    .clk(clk), .reset(reset),
    .recv_val(u_rv), .recv_rdy(u_rdy), .a(u_a), .b(u_b),
    .send_val(u_sv), .send_rdy(u_sr), .c(u_c), .dbz(u_dz), .ovf(u_ov)
  );

  function automatic void ref_div(input bit uns, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] c,
                                  output logic dz, output logic ov);
    longint          qa, qb, q;
    longint unsigned nu, qu;
    dz = 1'b0;
    ov = 1'b0;
    c  = '0;
    if (b == 32'h0) begin
      dz = 1'b1;
      if (uns) c = 32'hFFFFFFFF;
      else c = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (uns) begin
      nu = {32'h0, a} << 16;
      qu = nu / {32'h0, b};
      if (qu > 64'hFFFFFFFF) begin
        ov = 1'b1;
        c  = 32'hFFFFFFFF;
      end else c = qu[31:0];
    end else begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
      q  = (qa * 64'sd65536) / qb;
      if (q > MAXP) begin
        ov = 1'b1;
        c  = 32'h7FFFFFFF;
      end else if (q < MINN) begin
        ov = 1'b1;
        c  = 32'h80000000;
      end else c = q[31:0];
    end
  endfunction

  // Drives one full transaction; called at #1 after an edge while in IDLE.
  task automatic run_op(input bit uns, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c, output logic dz, output logic ov,
                        output int lat);
    int k;
    if (uns) begin u_rv = 1'b1; u_a = a; u_b = b; end
    else begin s_rv = 1'b1; s_a = a; s_b = b; end
    @(posedge clk); #1;
    s_rv = 1'b0;
    u_rv = 1'b0;
    k = 0;
    while (!(uns ? u_sv : s_sv) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    lat = k + 1;
    c  = uns ? u_c : s_c;
    dz = uns ? u_dz : s_dz;
    ov = uns ? u_ov : s_ov;
    if (uns) u_sr = 1'b1;
    else s_sr = 1'b1;
    @(posedge clk); #1;
    s_sr = 1'b0;
    u_sr = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({s_rdy, s_sv, s_c, s_dz, s_ov} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_signed: rdy=%b val=%b c=%h dbz=%b ovf=%b, want rdy=1 val=0 c=0 dbz=0 ovf=0",
               s_rdy, s_sv, s_c, s_dz, s_ov);
    end
    n_chk++;
    if ({u_rdy, u_sv, u_c, u_dz, u_ov} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_unsigned: rdy=%b val=%b c=%h dbz=%b ovf=%b, want rdy=1 val=0 c=0 dbz=0 ovf=0",
               u_rdy, u_sv, u_c, u_dz, u_ov);
    end
  endtask

  typedef struct {
    bit          uns;
    logic [31:0] a, b, c;
    logic        dz, ov;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] c;
    logic        dz, ov;
    int          lat;
    v.push_back('{1'b0, 32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0});
    v.push_back('{1'b0, 32'hFFFD0000, 32'h00020000, 32'hFFFE8000, 1'b0, 1'b0});
    v.push_back('{1'b0, 32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0});
    v.push_back('{1'b0, 32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0});
    v.push_back('{1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0});
    v.push_back('{1'b0, 32'h40000000, 32'h00000100, 32'h7FFFFFFF, 1'b0, 1'b1});
    v.push_back('{1'b1, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 1'b0, 1'b0});
    v.push_back('{1'b0, 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0});
    v.push_back('{1'b0, 32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b0, 1'b1});
    foreach (v[i]) begin
      run_op(v[i].uns, v[i].a, v[i].b, c, dz, ov, lat);
      n_chk++;
      if ({c, dz, ov} !== {v[i].c, v[i].dz, v[i].ov}) begin
        n_fail++;
        $display("FAIL directed[%0d] %h/%h: c=%h dbz=%b ovf=%b, want c=%h dbz=%b ovf=%b",
                 i, v[i].a, v[i].b, c, dz, ov, v[i].c, v[i].dz, v[i].ov);
      end
      n_chk++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_random(input bit uns, input int cnt);
    logic [31:0] a, b, c, ec;
    logic        dz, ov, edz, eov;
    int          lat, k;
    for (int i = 0; i < cnt; i++) begin
      a = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 32'h0;
      else if (k <= 2) b = $urandom_range(1, 255);
      else if (k == 3) b = $urandom;
      else b = $urandom >> $urandom_range(0, 20);
      if (b == 32'h0 && k != 0) b = 32'h1;
      if (k == 5) a = 32'h80000000;
      ref_div(uns, a, b, ec, edz, eov);
      run_op(uns, a, b, c, dz, ov, lat);
      n_chk++;
      if ({c, dz, ov, lat} !== {ec, edz, eov, LAT}) begin
        n_fail++;
        $display("FAIL random_%s[%0d] %h/%h: c=%h dbz=%b ovf=%b lat=%0d, want c=%h dbz=%b ovf=%b lat=%0d",
                 uns ? "u" : "s", i, a, b, c, dz, ov, lat, ec, edz, eov, LAT);
      end
    end
  endtask

  task automatic test_hold();
    int k;
    s_rv = 1'b1;
    s_a  = 32'h00030000;
    s_b  = 32'h00020000;
    @(posedge clk); #1;
    s_rv = 1'b0;
    k = 0;
    while (!s_sv && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      s_rv = 1'b1;
      s_a  = $urandom;
      s_b  = $urandom;
      @(posedge clk); #1;
      n_chk++;
      if ({s_sv, s_rdy, s_c, s_dz, s_ov} !== {1'b1, 1'b0, 32'h00018000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d]: val=%b rdy=%b c=%h dbz=%b ovf=%b, want val=1 rdy=0 c=00018000 dbz=0 ovf=0",
                 i, s_sv, s_rdy, s_c, s_dz, s_ov);
      end
    end
    s_rv = 1'b0;
    s_sr = 1'b1;
    @(posedge clk); #1;
    s_sr = 1'b0;
    n_chk++;
    if ({s_sv, s_rdy, s_c} !== {1'b0, 1'b1, 32'h00018000}) begin
      n_fail++;
      $display("FAIL hold_release: val=%b rdy=%b c=%h, want val=0 rdy=1 c=00018000",
               s_sv, s_rdy, s_c);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] c;
    logic        dz, ov;
    int          lat;
    s_rv = 1'b1;
    s_a  = 32'h00050000;
    s_b  = 32'h00030000;
    @(posedge clk); #1;
    s_rv = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    s_rv  = 1'b1;
    s_a   = 32'h00070000;
    s_b   = 32'h00010000;
    @(posedge clk); #1;
    reset = 1'b0;
    s_rv  = 1'b0;
    n_chk++;
    if ({s_rdy, s_sv, s_c, s_dz, s_ov} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b val=%b c=%h dbz=%b ovf=%b, want rdy=1 val=0 c=0 dbz=0 ovf=0",
               s_rdy, s_sv, s_c, s_dz, s_ov);
    end
    run_op(1'b0, 32'h00060000, 32'h00020000, c, dz, ov, lat);
    n_chk++;
    if ({c, dz, ov, lat} !== {32'h00030000, 1'b0, 1'b0, LAT}) begin
      n_fail++;
      $display("FAIL after_reset: c=%h dbz=%b ovf=%b lat=%0d, want c=00030000 dbz=0 ovf=0 lat=%0d",
               c, dz, ov, lat, LAT);
    end
  endtask

  initial begin
    reset = 1'b1;
    s_rv = 1'b0; s_sr = 1'b0; s_a = '0; s_b = '0;
    u_rv = 1'b0; u_sr = 1'b0; u_a = '0; u_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_random(1'b0, 40);
    test_random(1'b1, 20);
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
